// File: rtl/instr_mem_pkg.sv
// Shared widths, state encoding and boot program for the loadable
// instruction memory.
package instr_mem_pkg;

  localparam int OPC_W = 3;
  localparam int REG_W = 4;
  localparam int IMM_W = 10;
  localparam int INSTR_MIN_W = OPC_W + REG_W + IMM_W;

  localparam logic [INSTR_MIN_W-1:0] NOP_CODE = '0;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int BOOT_LEN = 5;

  // Boot words are {opcode, reg, imm} with opcode and reg zero.
  function automatic logic [INSTR_MIN_W-1:0] boot_word(input int idx);
    logic [IMM_W-1:0] imm;
    case (idx)
      0:       imm = 10'h000;
      1:       imm = 10'h001;
      2:       imm = 10'h002;
      3:       imm = 10'h020;
      4:       imm = 10'h050;
      default: imm = 10'h000;
    endcase
    return {{OPC_W{1'b0}}, {REG_W{1'b0}}, imm};
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W register storage: one write port, one registered read port.
// Reset contents are the boot program when IMEM_PRELOAD_EN is defined.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int DATA_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == ADDR_W'(i)) mem_d[i] = wr_data;
      end
    end
  end

  // Unmatched addresses fall through to NOP.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = DATA_W'(NOP_CODE);
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr == ADDR_W'(i)) rd_data_d = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef IMEM_PRELOAD_EN
        mem_q[i] <= (i < BOOT_LEN) ? DATA_W'(boot_word(i))
                                   : DATA_W'(NOP_CODE);
`else
        mem_q[i] <= DATA_W'(NOP_CODE);
`endif
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory: LOAD/RUN controller, range checks, error pulses.
// Define IMEM_PRELOAD_EN to boot straight into RUN with the built-in program.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int DATA_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_code,
  output logic              fetch_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

`ifdef IMEM_PRELOAD_EN
  localparam state_e RST_STATE = ST_RUN;
`else
  localparam state_e RST_STATE = ST_LOAD;
`endif

  state_e state_q, state_d;
  logic   fetch_valid_q, fetch_valid_d;
  logic   fetch_err_q, fetch_err_d;
  logic   load_err_q, load_err_d;
  logic   fetch_addr_ok, load_addr_ok;
  logic   wr_en, rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RST_STATE;
    else     state_q <= state_d;
  end

  // RUN is terminal; only reset returns to LOAD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: if (load_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    fetch_ready   = (state_q == ST_RUN);
    fetch_addr_ok = ({1'b0, fetch_addr} < DEPTH_L);
    load_addr_ok  = ({1'b0, load_addr} < DEPTH_L);
    wr_en         = !fetch_ready && load_en && load_addr_ok;
    rd_en         = fetch_ready && fetch_req;
    fetch_valid_d = rd_en;
    fetch_err_d   = rd_en && !fetch_addr_ok;
    load_err_d    = load_en && (fetch_ready || !load_addr_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      load_err_q    <= load_err_d;
    end
  end

  instr_mem_array #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(load_addr),
    .wr_data(load_data),
    .rd_en  (rd_en),
    .rd_addr(fetch_addr),
    .rd_data(fetch_code)
  );

  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem (DEPTH=40) against an array model.
// Preload scenarios run when IMEM_PRELOAD_EN is defined.
module tb_instr_mem;

  localparam int AW = 6;
  localparam int DP = 40;
  localparam int DW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_code;
  logic          fetch_err;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_done;
  logic          load_err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mdl [2**AW];
  logic          mdl_run;
  logic [DW-1:0] last_code;

  always #5 clk = ~clk;

  instr_mem #(.ADDR_W(AW), .DEPTH(DP), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_code (fetch_code),
    .fetch_err  (fetch_err),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
`ifdef IMEM_PRELOAD_EN
    mdl[1] = 23'h001; mdl[2] = 23'h002;
    mdl[3] = 23'h020; mdl[4] = 23'h050;
    mdl_run = 1'b1;
`else
    mdl_run = 1'b0;
`endif
    last_code = '0;
  endtask

  task automatic idle_inputs();
    fetch_req = 0; fetch_addr = '0; load_en = 0;
    load_addr = '0; load_data = '0; load_done = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || load_err !== 1'b0
        || fetch_code !== '0 || fetch_ready !== mdl_run) begin
      errors++;
      $display("FAIL reset_outputs got v=%b e=%b le=%b code=%h rdy=%b want 0 0 0 0 rdy=%b",
               fetch_valid, fetch_err, load_err, fetch_code, fetch_ready, mdl_run);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch_in_load();
    @(negedge clk);
    fetch_req = 1; fetch_addr = '0;
    tick();
    checks++;
    if (fetch_ready !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_in_load got rdy=%b v=%b want 0 0", fetch_ready, fetch_valid);
    end
    @(negedge clk);
    fetch_req = 0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
    logic exp_err;
    @(negedge clk);
    load_en = 1; load_addr = a; load_data = d; load_done = done;
    exp_err = mdl_run || (int'(a) >= DP);
    if (!exp_err) mdl[a] = d;
    if (done) mdl_run = 1'b1;
    tick();
    checks++;
    if (load_err !== exp_err) begin
      errors++;
      $display("FAIL load_err_pulse a=%0d got %b want %b", a, load_err, exp_err);
    end
    @(negedge clk);
    load_en = 0; load_done = 0;
    tick();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_clear got %b want 0", load_err);
    end
  endtask

  task automatic test_load();
    do_load(6'd3, 23'h12345, 1'b0);
    do_load(6'd50, 23'h7ABCDE, 1'b0);
    do_load(6'd40, 23'h000111, 1'b0);
    for (int i = 0; i < 12; i++)
      do_load(6'($urandom_range(0, DP - 1)), 23'($urandom), 1'b0);
    do_load(6'd3, 23'h12345, 1'b0);
  endtask

  task automatic test_load_done_same_cycle();
    do_load(6'd1, 23'h55, 1'b1);
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_done got %b want 1", fetch_ready);
    end
  endtask

  // Back-to-back fetch of a list; one result expected every cycle.
  task automatic fetch_seq(input int n, input logic [AW-1:0] addrs [64]);
    logic [DW-1:0] ec;
    logic ee;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fetch_req = 1; fetch_addr = addrs[i];
      ee = int'(addrs[i]) >= DP;
      ec = ee ? '0 : mdl[addrs[i]];
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_code !== ec || fetch_err !== ee) begin
        errors++;
        $display("FAIL fetch a=%0d got v=%b code=%h err=%b want v=1 code=%h err=%b",
                 addrs[i], fetch_valid, fetch_code, fetch_err, ec, ee);
      end
      last_code = ec;
    end
    @(negedge clk);
    fetch_req = 0;
  endtask

  task automatic test_fetch();
    logic [AW-1:0] a [64];
    a[0] = 6'd3; a[1] = 6'd1; a[2] = 6'd45; a[3] = 6'd39; a[4] = 6'd40;
    for (int i = 5; i < 30; i++) a[i] = 6'($urandom_range(0, 63));
    fetch_seq(30, a);
  endtask

  task automatic test_hold();
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_code !== last_code) begin
      errors++;
      $display("FAIL hold got v=%b e=%b code=%h want 0 0 %h",
               fetch_valid, fetch_err, fetch_code, last_code);
    end
  endtask

  task automatic test_run_load_rejected();
    logic [AW-1:0] a [64];
    do_load(6'd2, 23'h7FFFFF, 1'b0);
    do_load(6'd2, 23'h7FFFFF, 1'b1);
    a[0] = 6'd2;
    fetch_seq(1, a);
  endtask

  task automatic test_preload();
    logic [AW-1:0] a [64];
    for (int i = 0; i < 6; i++) a[i] = 6'(i);
    fetch_seq(6, a);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    fetch_req = 1; fetch_addr = 6'd3;
    @(posedge clk);
    #1 rst = 1'b1;
    fetch_req = 0;
    model_reset();
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || load_err !== 1'b0
        || fetch_code !== '0 || fetch_ready !== mdl_run) begin
      errors++;
      $display("FAIL midflight_reset got v=%b e=%b le=%b code=%h rdy=%b want 0 0 0 0 %b",
               fetch_valid, fetch_err, load_err, fetch_code, fetch_ready, mdl_run);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_dropped got v=%b want 0", fetch_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
`ifdef IMEM_PRELOAD_EN
    test_preload();
    test_run_load_rejected();
    test_fetch();
    test_hold();
`else
    test_fetch_in_load();
    test_load();
    test_load_done_same_cycle();
    test_fetch();
    test_hold();
    test_run_load_rejected();
`endif
    test_reset_midflight();
`ifndef IMEM_PRELOAD_EN
    test_fetch_in_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
